// File: rtl/fetch_sink_if.sv
// Fetch/issue handshake bundle for fetch_sink.
// master = fetch stage plus issue stage (stimulus side), slave = the sink.
interface fetch_sink_if;
    logic        fetch_valid_i;
    logic [31:0] fetch_instr_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_branch_o;
    logic [31:0] fetch_branch_pc_o;
    logic        fetch_stall_o;
    logic        issue_valid_o;
    logic [31:0] issue_instr_o;
    logic [31:0] issue_pc_o;
    logic        issue_accept_i;
    logic [4:0]  issue_rs1_o;
    logic [4:0]  issue_rs2_o;
    logic [4:0]  issue_rd_o;
    logic        pc_error_o;
    logic [31:0] accept_count_o;

    modport master (
        output fetch_valid_i, fetch_instr_i, fetch_pc_i, issue_accept_i,
        input  fetch_branch_o, fetch_branch_pc_o, fetch_stall_o,
        input  issue_valid_o, issue_instr_o, issue_pc_o,
        input  issue_rs1_o, issue_rs2_o, issue_rd_o, pc_error_o, accept_count_o
    );

    modport slave (
        input  fetch_valid_i, fetch_instr_i, fetch_pc_i, issue_accept_i,
        output fetch_branch_o, fetch_branch_pc_o, fetch_stall_o,
        output issue_valid_o, issue_instr_o, issue_pc_o,
        output issue_rs1_o, issue_rs2_o, issue_rd_o, pc_error_o, accept_count_o
    );
endinterface

// File: rtl/fetch_sink.sv
// Consumer end of the fetch interface: opcode FIFO toward issue, static
// redirect prediction back to fetch, and PC-flow checking.
//
// state   | meaning
// S_IDLE  | no redirect outstanding; opcodes may be accepted
// S_REDIR | redirect pulse on fetch_branch_o; offered opcode is wrong-path
module fetch_sink #(
    parameter int unsigned DEPTH       = 2,
    parameter logic [31:0] RESET_PC    = 32'h100,
    parameter bit          REDIRECT_EN = 1'b1
) (
    input logic        clk_i,
    input logic        rst_i,
    fetch_sink_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_REDIR} state_t;

    state_t             state;
    logic               branch_q;
    logic [31:0]        branch_pc_q;
    logic [31:0]        mem_instr [DEPTH];
    logic [31:0]        mem_pc    [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [31:0]        exp_pc;
    logic               pc_error;
    logic [31:0]        accept_cnt;

    logic               stall;
    logic               push;
    logic               pop;
    logic               is_jal;
    logic               is_bwd_br;
    logic               redirect;
    logic [31:0]        jal_imm;
    logic [31:0]        br_imm;
    logic [31:0]        target;
    logic [31:0]        head_instr;

    always_comb begin
        stall     = (count == CNT_W'(DEPTH));
        push      = bus.fetch_valid_i && !stall && !branch_q;
        pop       = bus.issue_accept_i && (count != '0);
        jal_imm   = {{11{bus.fetch_instr_i[31]}}, bus.fetch_instr_i[31],
                     bus.fetch_instr_i[19:12], bus.fetch_instr_i[20],
                     bus.fetch_instr_i[30:21], 1'b0};
        br_imm    = {{19{bus.fetch_instr_i[31]}}, bus.fetch_instr_i[31],
                     bus.fetch_instr_i[7], bus.fetch_instr_i[30:25],
                     bus.fetch_instr_i[11:8], 1'b0};
        is_jal    = (bus.fetch_instr_i[6:0] == 7'h6f);
        is_bwd_br = (bus.fetch_instr_i[6:0] == 7'h63) && bus.fetch_instr_i[31];
        redirect  = REDIRECT_EN && (is_jal || is_bwd_br);
        target    = bus.fetch_pc_i + (is_jal ? jal_imm : br_imm);
    end

    // FIFO storage; the head is read from registers only, so a push is never
    // visible on issue_* in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= bus.fetch_instr_i;
                mem_pc[wr_ptr]    <= bus.fetch_pc_i;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exp_pc     <= RESET_PC;
            pc_error   <= 1'b0;
            accept_cnt <= '0;
        end else if (push) begin
            accept_cnt <= accept_cnt + 1'b1;
            if (bus.fetch_pc_i != exp_pc) pc_error <= 1'b1;
            exp_pc <= redirect ? target : bus.fetch_pc_i + 32'd4;
        end
    end

    // Redirect FSM; push is already blocked during S_REDIR, which is what
    // rules out back-to-back redirects.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            branch_q    <= 1'b0;
            branch_pc_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (push && redirect) begin
                        state       <= S_REDIR;
                        branch_q    <= 1'b1;
                        branch_pc_q <= target;
                    end else begin
                        branch_q <= 1'b0;
                    end
                end
                S_REDIR: begin
                    state    <= S_IDLE;
                    branch_q <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    branch_q <= 1'b0;
                end
            endcase
        end
    end

    assign head_instr            = mem_instr[rd_ptr];
    assign bus.fetch_stall_o     = stall;
    assign bus.fetch_branch_o    = branch_q;
    assign bus.fetch_branch_pc_o = branch_pc_q;
    assign bus.issue_valid_o     = (count != '0);
    assign bus.issue_instr_o     = head_instr;
    assign bus.issue_pc_o        = mem_pc[rd_ptr];
    assign bus.issue_rs1_o       = head_instr[19:15];
    assign bus.issue_rs2_o       = head_instr[24:20];
    assign bus.issue_rd_o        = head_instr[11:7];
    assign bus.pc_error_o        = pc_error;
    assign bus.accept_count_o    = accept_cnt;
endmodule

// File: tb/tb_fetch_sink.sv
// Directed and random stimulus for fetch_sink against a queue-based model.
module tb_fetch_sink;
    localparam int DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h100;
    localparam logic [31:0] ADDI = 32'h00a00093;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    fetch_sink_if bus();

    fetch_sink #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .REDIRECT_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    logic [31:0] q_instr[$];
    logic [31:0] q_pc[$];
    logic [31:0] m_exp;
    logic        m_err;
    logic [31:0] m_cnt;
    logic        m_br;
    logic [31:0] m_br_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_instr.delete();
        q_pc.delete();
        m_exp = RESET_PC;
        m_err = 1'b0;
        m_cnt = '0;
        m_br = 1'b0;
        m_br_pc = '0;
    endtask

    // Prediction rules: {redirects, target}
    function automatic logic [32:0] predict(input logic [31:0] ins, input logic [31:0] pc);
        int off;
        logic [20:0] j;
        logic [12:0] b;
        j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        if (ins[6:0] == 7'h6f) begin
            off = $signed(j);
            return {1'b1, pc + off};
        end
        if (ins[6:0] == 7'h63 && ins[31]) begin
            off = $signed(b);
            return {1'b1, pc + off};
        end
        return {1'b0, pc + 32'd4};
    endfunction

    task automatic check_all();
        chk("stall", {31'd0, bus.fetch_stall_o}, {31'd0, q_instr.size() == DEPTH});
        chk("issue_valid", {31'd0, bus.issue_valid_o}, {31'd0, q_instr.size() != 0});
        if (q_instr.size() != 0) begin
            chk("issue_instr", bus.issue_instr_o, q_instr[0]);
            chk("issue_pc", bus.issue_pc_o, q_pc[0]);
            chk("rs1", {27'd0, bus.issue_rs1_o}, {27'd0, q_instr[0][19:15]});
            chk("rs2", {27'd0, bus.issue_rs2_o}, {27'd0, q_instr[0][24:20]});
            chk("rd", {27'd0, bus.issue_rd_o}, {27'd0, q_instr[0][11:7]});
        end
        chk("branch", {31'd0, bus.fetch_branch_o}, {31'd0, m_br});
        chk("branch_pc", bus.fetch_branch_pc_o, m_br_pc);
        chk("pc_error", {31'd0, bus.pc_error_o}, {31'd0, m_err});
        chk("accept_count", bus.accept_count_o, m_cnt);
    endtask

    // Entered and left at posedge+1; outputs are checked at the falling edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic acc);
        logic take, pop, full;
        logic [32:0] p;
        bus.fetch_valid_i  = v;
        bus.fetch_instr_i  = ins;
        bus.fetch_pc_i     = pc;
        bus.issue_accept_i = acc;
        #4;
        check_all();
        full = (q_instr.size() == DEPTH);
        take = v && !full && !m_br;
        pop  = acc && (q_instr.size() != 0);
        @(posedge clk_i);
        if (pop) begin
            void'(q_instr.pop_front());
            void'(q_pc.pop_front());
        end
        m_br = 1'b0;
        if (take) begin
            q_instr.push_back(ins);
            q_pc.push_back(pc);
            m_cnt++;
            if (pc != m_exp) m_err = 1'b1;
            p = predict(ins, pc);
            m_exp = p[31:0];
            if (p[32]) begin
                m_br = 1'b1;
                m_br_pc = p[31:0];
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] r, ins, pc;
        bus.fetch_valid_i  = 1'b0;
        bus.fetch_instr_i  = '0;
        bus.fetch_pc_i     = '0;
        bus.issue_accept_i = 1'b0;
        model_reset();
        #1;
        chk("rst_issue_valid", {31'd0, bus.issue_valid_o}, 32'd0);
        chk("rst_issue_instr", bus.issue_instr_o, 32'd0);
        chk("rst_issue_pc", bus.issue_pc_o, 32'd0);
        chk("rst_branch", {31'd0, bus.fetch_branch_o}, 32'd0);
        chk("rst_count", bus.accept_count_o, 32'd0);
        do_reset();

        // sequential flow with the issue stage always accepting
        step(1, ADDI, 32'h100, 1); chk("seq_pc0", bus.issue_pc_o, 32'h100);
        step(1, ADDI, 32'h104, 1); chk("seq_pc1", bus.issue_pc_o, 32'h104);
        step(1, ADDI, 32'h108, 1); chk("seq_pc2", bus.issue_pc_o, 32'h108);
        chk("seq_count", bus.accept_count_o, 32'd3);
        step(0, 0, 0, 1);

        // back-pressure: third opcode held until a pop frees a slot
        step(1, ADDI, 32'h10c, 0);
        step(1, ADDI, 32'h110, 0);
        chk("bp_stall", {31'd0, bus.fetch_stall_o}, 32'd1);
        step(1, ADDI, 32'h114, 0);
        step(1, ADDI, 32'h114, 1);
        step(1, ADDI, 32'h114, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("bp_count", bus.accept_count_o, 32'd6);

        // redirects: JAL to 0x200, JAL 0x200->0x208, JAL 0x20c->0x300, backward beq
        do_reset();
        step(1, 32'h1000006f, 32'h100, 1);
        chk("jal0_target", bus.fetch_branch_pc_o, 32'h200);
        step(1, ADDI, 32'h104, 1);
        step(1, 32'h0080006f, 32'h200, 1);
        chk("jal_branch", {31'd0, bus.fetch_branch_o}, 32'd1);
        chk("jal_target", bus.fetch_branch_pc_o, 32'h208);
        step(1, ADDI, 32'h20c, 1);
        chk("jal_pulse_end", {31'd0, bus.fetch_branch_o}, 32'd0);
        chk("jal_pc_hold", bus.fetch_branch_pc_o, 32'h208);
        step(1, ADDI, 32'h208, 1);
        step(1, 32'h0f40006f, 32'h20c, 1);
        step(0, 0, 0, 1);
        step(1, 32'hfe000ee3, 32'h300, 1);
        chk("bwd_target", bus.fetch_branch_pc_o, 32'h2fc);
        step(0, 0, 0, 1);
        step(1, ADDI, 32'h2fc, 1);
        step(1, 32'h00000463, 32'h300, 1);
        chk("fwd_no_branch", {31'd0, bus.fetch_branch_o}, 32'd0);
        step(1, ADDI, 32'h304, 1);
        chk("redir_no_error", {31'd0, bus.pc_error_o}, 32'd0);
        step(0, 0, 0, 1);

        // sticky PC error
        do_reset();
        step(1, ADDI, 32'h100, 1);
        step(1, ADDI, 32'h10c, 1);
        chk("err_set", {31'd0, bus.pc_error_o}, 32'd1);
        step(1, ADDI, 32'h110, 1);
        step(1, ADDI, 32'h114, 1);
        chk("err_sticky", {31'd0, bus.pc_error_o}, 32'd1);
        step(0, 0, 0, 1);

        // random traffic
        do_reset();
        for (int n = 0; n < 500; n++) begin
            r = $urandom;
            case ($urandom_range(0, 5))
                0, 1:    ins = {r[31:7], 7'h13};
                2:       ins = {r[31:7], 7'h6f};
                3:       ins = {1'b1, r[30:7], 7'h63};
                4:       ins = {1'b0, r[30:7], 7'h63};
                default: ins = {r[31:7], 7'h67};
            endcase
            r = $urandom;
            pc = ($urandom_range(0, 19) == 0) ? {r[31:2], 2'b00} : m_exp;
            step($urandom_range(0, 3) != 0, ins, pc, $urandom_range(0, 2) != 0);
        end

        // asynchronous reset with FIFO full, error set and redirect pending
        do_reset();
        step(1, ADDI, 32'h108, 0);
        step(1, 32'h1000006f, 32'h10c, 0);
        chk("pre_rst_full", {31'd0, bus.fetch_stall_o}, 32'd1);
        chk("pre_rst_branch", {31'd0, bus.fetch_branch_o}, 32'd1);
        chk("pre_rst_err", {31'd0, bus.pc_error_o}, 32'd1);
        #1 rst_i = 1'b1;
        #1;
        chk("arst_stall", {31'd0, bus.fetch_stall_o}, 32'd0);
        chk("arst_valid", {31'd0, bus.issue_valid_o}, 32'd0);
        chk("arst_instr", bus.issue_instr_o, 32'd0);
        chk("arst_pc", bus.issue_pc_o, 32'd0);
        chk("arst_branch", {31'd0, bus.fetch_branch_o}, 32'd0);
        chk("arst_branch_pc", bus.fetch_branch_pc_o, 32'd0);
        chk("arst_err", {31'd0, bus.pc_error_o}, 32'd0);
        chk("arst_count", bus.accept_count_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        step(1, ADDI, 32'h100, 1);
        step(1, ADDI, 32'h104, 1);
        chk("post_rst_no_err", {31'd0, bus.pc_error_o}, 32'd0);
        step(0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_sink.md
Name: fetch_sink

Overview:
- Consumer end of the fetch interface. Accepts the opcode stream presented by the fetch stage (or a fetch stimulus model) and buffers it in a small FIFO for the issue stage.
- Applies back-pressure through stall and generates static-prediction redirects (branch, branch_pc) back to fetch.
- Checks that every accepted PC follows the expected sequential or redirected flow, and flags any break.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h100, expected PC of the first accepted instruction after reset.
- REDIRECT_EN, 1, 1 enables JAL and backward-branch redirects; 0 keeps fetch_branch_o at 0.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- fetch_valid_i  input  1  opcode valid from fetch.
- fetch_instr_i  input  32  fetched opcode.
- fetch_pc_i  input  32  PC of fetched opcode.
- fetch_branch_o  output  1  redirect request to fetch; single-cycle pulse.
- fetch_branch_pc_o  output  32  redirect target.
- fetch_stall_o  output  1  back-pressure to fetch.
- issue_valid_o  output  1  FIFO head valid.
- issue_instr_o  output  32  head opcode.
- issue_pc_o  output  32  head PC.
- issue_accept_i  input  1  issue stage pops head.
- issue_rs1_o  output  5  head opcode bits [19:15].
- issue_rs2_o  output  5  head opcode bits [24:20].
- issue_rd_o  output  5  head opcode bits [11:7].
- pc_error_o  output  1  sticky PC-sequence error.
- accept_count_o  output  32  count of accepted instructions.

Behaviour:
- Reset values: FIFO empty; issue_valid_o=0; issue_instr_o/issue_pc_o=0; fetch_branch_o=0; fetch_branch_pc_o=0; pc_error_o=0; accept_count_o=0; expected PC=RESET_PC. Reset asserted mid-operation discards all buffered entries and any pending redirect immediately.
- fetch_stall_o is combinational: asserted when count==DEPTH. It does not depend on issue_accept_i.
- Accept condition: fetch_valid_i && !fetch_stall_o && !fetch_branch_o. An opcode presented while fetch_branch_o=1 is wrong-path. It is dropped and is not PC-checked.
- Accept actions: push {instr, pc} at the tail, increment accept_count_o (wraps at 2^32), and compare fetch_pc_i to the expected PC.
  - On mismatch, set pc_error_o (sticky until reset).
  - On match or mismatch, update expected PC: the redirect target if the instruction redirects, else fetch_pc_i+4 (mod 2^32).
- Pop: issue_accept_i && issue_valid_o. Accept with issue_valid_o=0 is ignored.
- Simultaneous push and pop: count unchanged.
- Pointers wrap modulo DEPTH. Issue outputs are the registered FIFO head. Zero-latency bypass is not allowed: an opcode pushed in cycle N is visible on issue_* at N+1 at the earliest.
- Redirect decode, applied to the accepted opcode when REDIRECT_EN=1:
  - JAL (opcode[6:0]=7'h6f): target = pc + sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - Conditional branch (opcode[6:0]=7'h63) with instr[31]=1 (backward, predicted taken): target = pc + sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - Forward branches, JALR and all other opcodes: no redirect.
- Redirect timing: accept in cycle N → fetch_branch_o=1 and fetch_branch_pc_o=target in cycle N+1, exactly one cycle. fetch_branch_pc_o holds its last value afterwards. No accept occurs in N+1, so back-to-back redirects are impossible.
- State machine (redirect):
  - IDLE→REDIR on an accept of a redirecting opcode.
  - REDIR→IDLE unconditionally after one cycle.
  - Reset→IDLE.
- A stall in cycle N+1 does not suppress or delay the redirect pulse.
- Target arithmetic is 32-bit modulo; no alignment check.

Test Plan:
- Reset, then present addi at pc 0x100, 0x104, 0x108 with issue_accept_i=1 → issue_pc_o shows 0x100/0x104/0x108 one cycle after each push; pc_error_o=0; accept_count_o=3.
- issue_accept_i=0, three valid opcodes offered → first two accepted; fetch_stall_o=1 from the cycle after the second push; third held until one pop; no loss or duplication.
- JAL 32'h0080006f at pc 0x200 → next cycle fetch_branch_o=1 for one cycle with fetch_branch_pc_o=0x208; opcode offered that cycle dropped; next accepted pc 0x208 gives no error.
- beq 32'hfe000ee3 at pc 0x300 (backward, imm=-4) → redirect to 0x2fc; forward beq 32'h00000463 at pc 0x300 → no redirect, expected PC 0x304.
- Accept pc 0x100 then pc 0x10c → pc_error_o=1 and stays 1 through later correct PCs until rst_i.
- Assert rst_i asynchronously with FIFO full and a redirect pending → all outputs return to reset values without a clock edge; expected PC=0x100 after release.
